// File: rtl/multi_alarm_controller.sv
// Multi-channel alarm controller: per-channel time match, ring timeout, snooze and off handling.
// Optional snooze feature enabled by defining MULTI_ALARM_SNOOZE_EN.
module multi_alarm_controller #(
  parameter int NUM_ALARMS     = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int ID_W           = 2
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    clk_1hz_en,
  input  logic [4:0]              current_hours_in,
  input  logic [5:0]              current_minutes_in,
  input  logic [5*NUM_ALARMS-1:0] alarm_hours_in,
  input  logic [6*NUM_ALARMS-1:0] alarm_minutes_in,
  input  logic [NUM_ALARMS-1:0]   alarm_enable_in,
  input  logic                    alarm_off_btn,
  input  logic                    snooze_btn,
  output logic                    alarm_trigger_out,
  output logic [ID_W-1:0]         active_alarm_id_out,
  output logic                    snoozed_out
);

  // state      | meaning
  // ST_IDLE    | waiting for an unfired enabled channel to match current time
  // ST_RINGING | alarm sounding for active channel; ring timeout running
  // ST_SNOOZED | ring paused for active channel; snooze timer running
  typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZED} state_t;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_MIN * 60 - 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_ALARMS-1:0]  fired;
  logic                   off_q;
  logic                   off_edge;
  logic                   snooze_edge;
  logic [NUM_ALARMS-1:0]  match;
  logic [NUM_ALARMS-1:0]  start_vec;
  logic                   start_ok;
  logic [ID_W-1:0]        start_id;
  logic                   active_en;

  assign off_edge = alarm_off_btn & ~off_q;

`ifdef MULTI_ALARM_SNOOZE_EN
  logic snooze_q;
  assign snooze_edge = snooze_btn & ~snooze_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) snooze_q <= 1'b0;
    else        snooze_q <= snooze_btn;
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze_btn;
  assign snooze_edge   = 1'b0;
`endif

  always_comb begin
    match     = '0;
    start_vec = '0;
    start_ok  = 1'b0;
    start_id  = '0;
    active_en = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = alarm_enable_in[i]
                 && (alarm_hours_in[5*i +: 5] == current_hours_in)
                 && (alarm_minutes_in[6*i +: 6] == current_minutes_in);
      // ascending scan with a found flag gives lowest index priority
      if (match[i] && !fired[i] && !start_ok) begin
        start_ok     = 1'b1;
        start_id     = ID_W'(i);
        start_vec[i] = 1'b1;
      end
      if (ID_W'(i) == active_alarm_id_out) active_en = alarm_enable_in[i];
    end
  end

  // Fired flag only blocks re-triggering while the matching minute persists.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fired <= '0;
      off_q <= 1'b0;
    end else begin
      fired <= match & (fired | ((state == ST_IDLE) ? start_vec : '0));
      off_q <= alarm_off_btn;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      alarm_trigger_out   <= 1'b0;
      active_alarm_id_out <= '0;
      snoozed_out         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state               <= ST_RINGING;
            cnt                 <= '0;
            alarm_trigger_out   <= 1'b1;
            active_alarm_id_out <= start_id;
          end
        end
        ST_RINGING: begin
          if (off_edge || !active_en) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            alarm_trigger_out   <= 1'b0;
            active_alarm_id_out <= '0;
            snoozed_out         <= 1'b0;
          end else if (snooze_edge) begin
            state             <= ST_SNOOZED;
            cnt               <= '0;
            alarm_trigger_out <= 1'b0;
            snoozed_out       <= 1'b1;
          end else if (clk_1hz_en) begin
            if (cnt == RING_LAST) begin
              state               <= ST_IDLE;
              cnt                 <= '0;
              alarm_trigger_out   <= 1'b0;
              active_alarm_id_out <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_SNOOZED: begin
          if (off_edge || !active_en) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            alarm_trigger_out   <= 1'b0;
            active_alarm_id_out <= '0;
            snoozed_out         <= 1'b0;
          end else if (clk_1hz_en) begin
            if (cnt == SNOOZE_LAST) begin
              state             <= ST_RINGING;
              cnt               <= '0;
              alarm_trigger_out <= 1'b1;
              snoozed_out       <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state               <= ST_IDLE;
          cnt                 <= '0;
          alarm_trigger_out   <= 1'b0;
          active_alarm_id_out <= '0;
          snoozed_out         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Bench for multi_alarm_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_multi_alarm_controller;
  localparam int N      = 4;
  localparam int SNZ_M  = 1;
  localparam int RING_S = 10;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst_n   = 1'b0;
  logic tick    = 1'b0;
  logic off     = 1'b0;
  logic sn      = 1'b0;
  logic [4:0] hrs  = '0;
  logic [5:0] mins = '0;
  logic [4:0] ahrs  [N];
  logic [5:0] amins [N];
  logic [N-1:0] en = '0;
  logic [5*N-1:0] ahrs_bus;
  logic [6*N-1:0] amins_bus;
  logic trig_o, snz_o;
  logic [1:0] id_o;

  int tests = 0;
  int fails = 0;

  bit m_ring, m_snz, m_off_p, m_sn_p;
  int m_id, m_secs;
  bit m_fired [N];

  always begin
    #5;
    if (clk_run) sys_clk = ~sys_clk;
  end

  always_comb begin
    ahrs_bus  = '0;
    amins_bus = '0;
    for (int i = 0; i < N; i++) begin
      ahrs_bus[5*i +: 5]  = ahrs[i];
      amins_bus[6*i +: 6] = amins[i];
    end
  end

  multi_alarm_controller #(
    .NUM_ALARMS(N), .SNOOZE_MIN(SNZ_M), .RING_TIMEOUT_S(RING_S), .ID_W(2)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .clk_1hz_en(tick),
    .current_hours_in(hrs), .current_minutes_in(mins),
    .alarm_hours_in(ahrs_bus), .alarm_minutes_in(amins_bus),
    .alarm_enable_in(en), .alarm_off_btn(off), .snooze_btn(sn),
    .alarm_trigger_out(trig_o), .active_alarm_id_out(id_o), .snoozed_out(snz_o)
  );

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ring = 0; m_snz = 0; m_id = 0; m_secs = 0; m_off_p = 0; m_sn_p = 0;
    for (int i = 0; i < N; i++) m_fired[i] = 0;
  endtask

  task automatic model_idle();
    m_ring = 0; m_snz = 0; m_id = 0; m_secs = 0;
  endtask

  // One second-level view of the alarm rules, evaluated once per sys_clk edge.
  task automatic model_step();
    bit mt [N];
    int started;
    bit off_e, sn_e;
    started = -1;
    off_e = off && !m_off_p;
    sn_e  = SNZ && sn && !m_sn_p;
    for (int i = 0; i < N; i++)
      mt[i] = en[i] && (ahrs[i] == hrs) && (amins[i] == mins);
    if (!m_ring && !m_snz) begin
      for (int i = N - 1; i >= 0; i--)
        if (mt[i] && !m_fired[i]) started = i;
      if (started >= 0) begin
        m_ring = 1; m_id = started; m_secs = 0;
      end
    end else if (off_e || !en[m_id]) begin
      model_idle();
    end else if (m_ring && sn_e) begin
      m_ring = 0; m_snz = 1; m_secs = 0;
    end else if (tick) begin
      m_secs++;
      if (m_ring && m_secs == RING_S) model_idle();
      else if (m_snz && m_secs == SNZ_M * 60) begin
        m_snz = 0; m_ring = 1; m_secs = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!mt[i]) m_fired[i] = 0;
      else if (i == started) m_fired[i] = 1;
    end
    m_off_p = off;
    m_sn_p  = sn;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
    check("trigger", trig_o, int'(m_ring));
    check("snoozed", snz_o, int'(m_snz));
    check("id", id_o, (m_ring || m_snz) ? m_id : 0);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      tick = 1; cycle();
      tick = 0; cycle();
    end
  endtask

  // Called at posedge+1; releases well before the next edge.
  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #1;
    check("rst_trigger", trig_o, 0);
    check("rst_snoozed", snz_o, 0);
    check("rst_id", id_o, 0);
    #2;
    rst_n = 1;
  endtask

  task automatic set_alarm(input int ch, input int h, input int m, input bit e);
    ahrs[ch]  = 5'(h);
    amins[ch] = 6'(m);
    en[ch]    = e;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_alarm(i, 0, 0, 0);
    off = 0; sn = 0; tick = 0;
    hrs = 5'd12; mins = 6'd30;
  endtask

  initial begin
    clear_all();
    @(posedge sys_clk);
    #1;
    do_reset();

    // ch2 at 07:15: 1-cycle latency, off, no re-ring in same minute
    set_alarm(2, 7, 15, 1);
    hrs = 7; mins = 14;
    cycle(); cycle();
    check("r35_pre_trig", trig_o, 0);
    mins = 15;
    cycle();
    check("r35_trig", trig_o, 1);
    check("r35_id", id_o, 2);
    off = 1;
    cycle();
    check("r35_off", trig_o, 0);
    cycle(); off = 0; cycle(); cycle();
    check("r35_no_rering", trig_o, 0);

    // ch1 and ch3 same time: lowest wins, ch3 follows after off
    clear_all(); do_reset();
    set_alarm(1, 6, 0, 1); set_alarm(3, 6, 0, 1);
    hrs = 6; mins = 0;
    cycle();
    check("r36_id1", id_o, 1);
    off = 1;
    cycle();
    check("r36_off", trig_o, 0);
    cycle();
    check("r36_trig3", trig_o, 1);
    check("r36_id3", id_o, 3);
    off = 0; cycle();

    // ring timeout
    clear_all(); do_reset();
    set_alarm(0, 8, 0, 1);
    hrs = 8; mins = 0;
    cycle();
    pulses(9);
    check("r37_nine", trig_o, 1);
    pulses(1);
    check("r37_ten", trig_o, 0);

`ifdef MULTI_ALARM_SNOOZE_EN
    clear_all(); do_reset();
    set_alarm(0, 8, 0, 1);
    hrs = 8; mins = 0;
    cycle();
    sn = 1;
    cycle();
    check("r38_snz_trig", trig_o, 0);
    check("r38_snz", snz_o, 1);
    sn = 0;
    pulses(59);
    check("r38_59", snz_o, 1);
    pulses(1);
    check("r38_back_trig", trig_o, 1);
    check("r38_back_id", id_o, 0);
    check("r38_back_snz", snz_o, 0);
`endif

    // off and snooze together, then enable drop
    clear_all(); do_reset();
    set_alarm(0, 9, 0, 1);
    hrs = 9; mins = 0;
    cycle();
    off = 1; sn = 1;
    cycle();
    check("r39_both_trig", trig_o, 0);
    check("r39_both_snz", snz_o, 0);
    off = 0; sn = 0;
    cycle();
    clear_all(); do_reset();
    set_alarm(0, 9, 0, 1);
    hrs = 9; mins = 0;
    cycle();
    en[0] = 0;
    cycle();
    check("r39_en_drop", trig_o, 0);

    // async reset with clock stopped, then re-ring
    set_alarm(0, 9, 0, 1);
    cycle(); cycle();
    check("r40_ring", trig_o, 1);
    clk_run = 0;
    #20;
    rst_n = 0;
    model_reset();
    #1;
    check("r40_trig0", trig_o, 0);
    check("r40_id0", id_o, 0);
    check("r40_snz0", snz_o, 0);
    #5;
    rst_n = 1;
    #3;
    clk_run = 1;
    cycle();
    check("r40_rering", trig_o, 1);

    // randomized traffic over a small time window to force collisions
    clear_all();
    for (int i = 0; i < N; i++)
      set_alarm(i, $urandom_range(0, 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    hrs = 0; mins = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 0) do_reset();
      if ($urandom_range(0, 19) == 0) begin
        hrs  = 5'($urandom_range(0, 1));
        mins = 6'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 29) == 0) en[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 149) == 0) off = ~off;
      if ($urandom_range(0, 14) == 0) sn = ~sn;
      tick = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_alarm_controller.md
MULTI_ALARM_CONTROLLER -- requirements
Module: multi_alarm_controller

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm channels (1..8).
REQ-002 Parameter SNOOZE_MIN, default 5, snooze length in minutes (1..30).
REQ-003 Parameter RING_TIMEOUT_S, default 60, ringing auto-off length in seconds (1..255).
REQ-004 Parameter ID_W, default 2, width of active_alarm_id_out; SHALL satisfy 2^ID_W >= NUM_ALARMS.
REQ-005 sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 clk_1hz_en  input  1  one-sys_clk-wide pulse per second.
REQ-008 current_hours_in  input  5  current hour, 0..23.
REQ-009 current_minutes_in  input  6  current minute, 0..59.
REQ-010 alarm_hours_in  input  5*NUM_ALARMS  per-channel alarm hour, channel i at bits [5i+4:5i].
REQ-011 alarm_minutes_in  input  6*NUM_ALARMS  per-channel alarm minute, channel i at bits [6i+5:6i].
REQ-012 alarm_enable_in  input  NUM_ALARMS  per-channel enable.
REQ-013 alarm_off_btn  input  1  level, synchronous to sys_clk; acted on at rising edge only.
REQ-014 snooze_btn  input  1  level, synchronous; acted on at rising edge only.
REQ-015 alarm_trigger_out  output  1  registered; high while RINGING.
REQ-016 active_alarm_id_out  output  ID_W  registered; index of channel owning RINGING/SNOOZED, 0 in IDLE.
REQ-017 snoozed_out  output  1  registered; high while SNOOZED.

Function
REQ-018 Channel i matches when alarm_enable_in[i]=1 and hours and minutes both equal current time.
REQ-019 Each channel SHALL hold a fired flag: set when that channel starts RINGING; cleared the first cycle its match is false; a channel with fired=1 SHALL NOT start ringing.
REQ-020 States: IDLE, RINGING, SNOOZED; single controller, one active channel at a time.
REQ-021 IDLE -> RINGING when any unfired channel matches; lowest index wins; alarm_trigger_out high on the sys_clk edge after the match is first visible (1-cycle latency).
REQ-022 Matches of other channels during RINGING/SNOOZED are ignored; they set no fired flag and may fire after return to IDLE if still matching.
REQ-023 Button actions use rising edge of an internally registered copy of each button; a held button acts once.
REQ-024 RINGING: seconds counter increments on clk_1hz_en; reaching RING_TIMEOUT_S -> IDLE.
REQ-025 alarm_off_btn edge in RINGING or SNOOZED -> IDLE next cycle; in IDLE no effect.
REQ-026 snooze_btn edge in RINGING -> SNOOZED; counter cleared; ignored in IDLE and SNOOZED.
REQ-027 SNOOZED: counter increments on clk_1hz_en; at SNOOZE_MIN*60 -> RINGING, same channel, ring counter cleared.
REQ-028 Off and snooze edges in the same cycle: off wins.
REQ-029 Active channel's alarm_enable_in dropping to 0 in RINGING or SNOOZED -> IDLE next cycle.
REQ-030 Counters SHALL be wide enough for 1800 s and SHALL NOT wrap; they clear on every state entry.
REQ-031 Time wrap 23:59 -> 00:00 needs no special handling; matching is pure equality.

Reset
REQ-032 rst_n low: state IDLE, counters 0, fired flags 0, button registers 0, alarm_trigger_out 0, active_alarm_id_out 0, snoozed_out 0, immediately and independent of sys_clk.
REQ-033 Reset mid-ring or mid-snooze SHALL abort it; after release a still-matching enabled channel rings again (fired cleared).

Configuration
REQ-034 Macro MULTI_ALARM_SNOOZE_EN: defined -> SNOOZED state and snooze_btn behave per REQ-026/027; undefined -> snooze_btn ignored, SNOOZED unreachable, snoozed_out tied 0, all other behaviour unchanged.

Verification (NUM_ALARMS=4, SNOOZE_MIN=1, RING_TIMEOUT_S=10, snooze macro defined)
REQ-035 Ch2 07:15 enabled, time 07:14 -> 07:15 -> trigger=1 one cycle later, id=2; off edge -> trigger=0, no re-ring while time stays 07:15.
REQ-036 Ch1 and ch3 both 06:00 enabled, time 06:00 -> id=1; after off, ch3 rings next cycle with id=3.
REQ-037 Ringing ch0, 10 clk_1hz_en pulses -> trigger=0, state IDLE; 9 pulses -> trigger still 1.
REQ-038 Ringing ch0, snooze edge -> trigger=0, snoozed_out=1; 60 pulses -> trigger=1, id=0, snoozed_out=0.
REQ-039 Ringing, off and snooze edges same cycle -> IDLE, snoozed_out=0; separately, clearing alarm_enable_in[0] while ringing -> trigger=0 next cycle.
REQ-040 rst_n low mid-ring with clock stopped -> all outputs 0 immediately; release with match still true -> trigger=1 one cycle later.
